alu_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU. It captures decoded operands and control from the decode stage and forwards results from EX/MEM and MEM/WB. It drives the ALU's two 32-bit operands and 4-bit opcode. It also detects load-use hazards, inserts bubbles, and honours stall and flush requests from the hazard/branch logic.

---
 rtl/alu_operand_stage.sv | 115 +++++++++++
 tb/tb_alu_operand_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decoded operands/control, forwards EX/MEM and MEM/WB results to the ALU.
// Latency: id_* visible one cycle after the capturing edge; forwarding is combinational (zero cycles).
// Backpressure: stall holds the stage, flush loads a bubble, load-use hazards insert a bubble and hold upstream.
module alu_operand_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_op,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] alu_in_one,
  output logic [31:0] alu_in_two,
  output logic [3:0]  alu_opcode,
  output logic [31:0] ex_store_data,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [4:0]  ex_rd,
  output logic        load_use_stall
);

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } stage_t;

  // A bubble writes nothing and targets XZR so it can never look like a hazard source.
  localparam stage_t BUBBLE = '{valid: 1'b0, rn: 5'd0, rm: 5'd0, rd: XZR,
                                read_data1: 32'd0, read_data2: 32'd0, imm: 32'd0,
                                alu_src: 1'b0, alu_op: 4'b0000,
                                reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  stage_t      q;
  stage_t      id_stage;
  logic [31:0] fwd_rn;
  logic [31:0] fwd_rm;

  // Pack the decode-stage inputs into one stage word.
  always_comb begin
    id_stage = '{valid: id_valid, rn: id_rn, rm: id_rm, rd: id_rd,
                 read_data1: id_read_data1, read_data2: id_read_data2, imm: id_imm,
                 alu_src: id_alu_src, alu_op: id_alu_op,
                 reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
  end

  // Stage register: flush beats stall, stall beats the load-use bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               q <= BUBBLE;
    else if (flush)          q <= BUBBLE;
    else if (stall)          q <= q;
    else if (load_use_stall) q <= BUBBLE;
    else                     q <= id_stage;
  end

  // Per-source forwarding; the younger EX/MEM result wins and XZR always reads its register value.
  always_comb begin
    fwd_rn = q.read_data1;
    if (exmem_reg_write && (exmem_rd == q.rn) && (q.rn != XZR))
      fwd_rn = exmem_result;
    else if (memwb_reg_write && (memwb_rd == q.rn) && (q.rn != XZR))
      fwd_rn = memwb_data;

    fwd_rm = q.read_data2;
    if (exmem_reg_write && (exmem_rd == q.rm) && (q.rm != XZR))
      fwd_rm = exmem_result;
    else if (memwb_reg_write && (memwb_rd == q.rm) && (q.rm != XZR))
      fwd_rm = memwb_data;
  end

  // Rm is forwarded even for immediate forms because stores need it.
  assign alu_in_one    = fwd_rn;
  assign alu_in_two    = q.alu_src ? q.imm : fwd_rm;
  assign ex_store_data = fwd_rm;

  assign alu_opcode    = q.valid ? q.alu_op : 4'b0000;
  assign ex_valid      = q.valid;
  assign ex_reg_write  = q.valid & q.reg_write;
  assign ex_mem_read   = q.valid & q.mem_read;
  assign ex_mem_write  = q.valid & q.mem_write;
  assign ex_rd         = q.rd;

  // A load in EX whose destination feeds the instruction in decode cannot be forwarded in time.
  assign load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rd != XZR) &
                          ((ex_rd == id_rn) | (ex_rd == id_rm));

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: reference model compared every cycle plus literal checks.
// Latency: model tracks the one-cycle stage and zero-cycle forwarding.
// Backpressure: exercises stall, flush, load-use bubbles and mid-stall reset.
module tb_alu_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_read_data1, id_read_data2, id_imm;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] alu_in_one, alu_in_two, ex_store_data;
  logic [3:0]  alu_opcode;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  alu_operand_stage dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_rn(id_rn), .id_rm(id_rm), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_in_one(alu_in_one), .alu_in_two(alu_in_two), .alu_opcode(alu_opcode),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
    .load_use_stall(load_use_stall)
  );

  always #5 clock = ~clock;

  // Reference model: what instruction currently sits in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  a_reg, b_reg, dst;
    logic [31:0] a_val, b_val, imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        wr, ld, st;
  } instr_t;

  instr_t m;

  function automatic instr_t nop_instr();
    instr_t n;
    n = '0;
    n.dst = 5'd31;
    return n;
  endfunction

  function automatic instr_t decoded_instr();
    instr_t n;
    n = '{v: id_valid, a_reg: id_rn, b_reg: id_rm, dst: id_rd,
          a_val: id_read_data1, b_val: id_read_data2, imm: id_imm,
          use_imm: id_alu_src, op: id_alu_op,
          wr: id_reg_write, ld: id_mem_read, st: id_mem_write};
    return n;
  endfunction

  // Value of an architectural register as the ALU must see it now.
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] file_val);
    if (r == 5'd31) return file_val;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_data;
    return file_val;
  endfunction

  function automatic logic hazard();
    return m.v && m.ld && id_valid && m.dst != 5'd31 && (m.dst == id_rn || m.dst == id_rm);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset)       m <= nop_instr();
    else if (flush)  m <= nop_instr();
    else if (!stall) m <= hazard() ? nop_instr() : decoded_instr();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("cmp_in_one", alu_in_one, reg_value(m.a_reg, m.a_val));
    chk("cmp_in_two", alu_in_two, m.use_imm ? m.imm : reg_value(m.b_reg, m.b_val));
    chk("cmp_store", ex_store_data, reg_value(m.b_reg, m.b_val));
    chk("cmp_opcode", 32'(alu_opcode), m.v ? 32'(m.op) : 32'd0);
    chk("cmp_valid", 32'(ex_valid), 32'(m.v));
    chk("cmp_reg_write", 32'(ex_reg_write), 32'(m.v & m.wr));
    chk("cmp_mem_read", 32'(ex_mem_read), 32'(m.v & m.ld));
    chk("cmp_mem_write", 32'(ex_mem_write), 32'(m.v & m.st));
    chk("cmp_rd", 32'(ex_rd), 32'(m.dst));
    chk("cmp_lus", 32'(load_use_stall), 32'(hazard()));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic [3:0] op,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_read_data1 = d1; id_read_data2 = d2; id_imm = imm;
    id_alu_src = src; id_alu_op = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_one", alu_in_one, 32'd0);
    chk("rst_in_two", alu_in_two, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd31);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_lus", 32'(load_use_stall), 32'd0);
    reset = 1'b0;

    // ADD X3, X1, X2 with 5 and 7
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 4'b0010, 1, 0, 0);
    tick();
    chk("add_in_one", alu_in_one, 32'd5);
    chk("add_in_two", alu_in_two, 32'd7);
    chk("add_opcode", 32'(alu_opcode), 32'h2);
    chk("add_valid", 32'(ex_valid), 32'd1);

    // EX/MEM beats MEM/WB on the same source; MEM/WB takes over same cycle when EX/MEM drops
    set_id(1, 5'd3, 5'd4, 5'd5, 32'h100, 32'h200, 32'd0, 0, 4'b0110, 1, 0, 0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hDEAD0000;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h1;
    tick();
    chk("fwd_exmem", alu_in_one, 32'hDEAD0000);
    chk("fwd_no_rm", alu_in_two, 32'h200);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", alu_in_one, 32'h1);

    // XZR never forwarded
    set_id(1, 5'd31, 5'd4, 5'd6, 32'd0, 32'h9, 32'd0, 0, 4'b0100, 1, 0, 0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd31; exmem_result = 32'hBAD;
    memwb_rd = 5'd31;
    tick();
    chk("xzr_in_one", alu_in_one, 32'd0);

    // Store with immediate; Rm still forwarded to store data
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_data = 32'h55;
    set_id(1, 5'd5, 5'd6, 5'd31, 32'd9, 32'h77, 32'h10, 1, 4'b0010, 0, 0, 1);
    tick();
    chk("imm_in_two", alu_in_two, 32'h10);
    chk("imm_store", ex_store_data, 32'h55);
    chk("imm_mem_write", 32'(ex_mem_write), 32'd1);

    // LDUR X2 then dependent SUB
    memwb_reg_write = 1'b0;
    set_id(1, 5'd5, 5'd10, 5'd2, 32'h40, 32'd0, 32'd8, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5'd2, 5'd7, 5'd4, 32'd0, 32'd3, 32'd0, 0, 4'b1010, 1, 0, 0);
    #1;
    chk("lu_stall_on", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bubble_op", 32'(alu_opcode), 32'd0);
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_stall_off", 32'(load_use_stall), 32'd0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_data = 32'h1234;
    tick();
    chk("lu_sub_one", alu_in_one, 32'h1234);
    chk("lu_sub_two", alu_in_two, 32'd3);
    chk("lu_sub_op", 32'(alu_opcode), 32'hA);

    // Stall three cycles with changing decode inputs
    memwb_reg_write = 1'b0;
    set_id(1, 5'd8, 5'd9, 5'd10, 32'hF0, 32'h0F, 32'd0, 0, 4'b1001, 1, 0, 0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(i + 11), 5'(i + 14), 5'(i + 17), 32'(i * 17 + 1), 32'(i * 29 + 2),
             32'(i), 1'(i), 4'(i + 3), 1, 0, 1);
      tick();
      chk("stall_one", alu_in_one, 32'hF0);
      chk("stall_two", alu_in_two, 32'h0F);
      chk("stall_op", 32'(alu_opcode), 32'h9);
    end

    // Flush beats stall
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_op", 32'(alu_opcode), 32'd0);
    chk("flush_rd", 32'(ex_rd), 32'd31);
    chk("flush_one", alu_in_one, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Stall with a pending load-use: stage holds, request stays up
    set_id(1, 5'd1, 5'd1, 5'd12, 32'd0, 32'd0, 32'd4, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5'd12, 5'd0, 5'd13, 32'd0, 32'd0, 32'd0, 0, 4'b0010, 1, 0, 0);
    stall = 1'b1;
    #1;
    chk("slu_on", 32'(load_use_stall), 32'd1);
    tick();
    chk("slu_held", 32'(load_use_stall), 32'd1);
    chk("slu_valid", 32'(ex_valid), 32'd1);
    chk("slu_rd", 32'(ex_rd), 32'd12);

    // Asynchronous reset mid-stall
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_rd", 32'(ex_rd), 32'd31);
    chk("arst_lus", 32'(load_use_stall), 32'd0);
    chk("arst_op", 32'(alu_opcode), 32'd0);
    #3 reset = 1'b0;
    stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
